// File: rtl/sklansky_addsub32_pipe_pkg.sv
// Shared constants for the pipelined Sklansky add/subtract unit.
package sklansky_addsub32_pipe_pkg;

  localparam int ADDSUB_WIDTH  = 32;
  localparam int PREFIX_LEVELS = 5;

  // Bit positions of the flags inside the registered status word.
  localparam int FLAG_COUT = 0;
  localparam int FLAG_OVF  = 1;
  localparam int FLAG_ZERO = 2;
  localparam int FLAG_NEG  = 3;
  localparam int FLAG_BITS = 4;

endpackage

// File: rtl/sklansky_gp_cell.sv
// Generate/propagate merge of a high group with the adjacent low group.
module sklansky_gp_cell (
  input  logic gh,
  input  logic ph,
  input  logic gl,
  input  logic pl,
  output logic g,
  output logic p
);

  assign g = gh | (ph & gl);
  assign p = ph & pl;

endmodule

// File: rtl/sklansky_addsub32_pipe.sv
// Two-stage 32-bit add/subtract unit: prefix levels are split across the two
// pipeline registers, with valid/ready flow control on both sides.
module sklansky_addsub32_pipe
  import sklansky_addsub32_pipe_pkg::*;
#(
  parameter int WIDTH       = ADDSUB_WIDTH,
  parameter int SPLIT_LEVEL = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             neg
);

  // Handshake: a beat moves on a side when valid && ready on that side in the
  // same cycle; in_ready is combinational from out_ready through both stages.
  logic s1_valid, s2_valid, s1_adv, s2_adv;

  assign s2_adv    = !s2_valid || out_ready;
  assign s1_adv    = !s1_valid || s2_adv;
  assign in_ready  = s1_adv;
  assign out_valid = s2_valid;

  logic [WIDTH-1:0] bi, pb, g0;
  logic             c0;

  assign bi = sub ? ~b : b;
  assign c0 = sub ? ~cin : cin;
  assign pb = a ^ bi;
  assign g0 = {a[WIDTH-1:1] & bi[WIDTH-1:1], (a[0] & bi[0]) | (pb[0] & c0)};

  logic [WIDTH-1:0]                  s1_g, s1_pb;
  logic [WIDTH-1:(1 << SPLIT_LEVEL)] s1_p;
  logic                              s1_c0, s1_sub, s1_a31, s1_bi31;

  // Group P is only kept for groups that do not yet reach bit 0; once a
  // group spans down to bit 0 its G is already the final carry.
  for (genvar l = 0; l < PREFIX_LEVELS; l++) begin : g_lvl
    logic [WIDTH-1:0]        gi, go;
    logic [WIDTH-1:(1 << l)] pi;

    if (l == 0) begin : g_src
      assign gi = g0;
      assign pi = pb[WIDTH-1:1];
    end else if (l == SPLIT_LEVEL) begin : g_src
      assign gi = s1_g;
      assign pi = s1_p;
    end else begin : g_src
      assign gi = g_lvl[l-1].go;
      assign pi = g_lvl[l-1].g_pout.po;
    end

    if (l < PREFIX_LEVELS - 1) begin : g_pout
      logic [WIDTH-1:(2 << l)] po;
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      localparam int J = ((i >> l) << l) - 1;
      if (((i >> l) & 1) == 0) begin : g_pass
        assign go[i] = gi[i];
        if (l < PREFIX_LEVELS - 1 && i >= (2 << l)) begin : g_pp
          assign g_pout.po[i] = pi[i];
        end
      end else if (i < (2 << l)) begin : g_gray
        assign go[i] = gi[i] | (pi[i] & gi[J]);
      end else begin : g_black
        sklansky_gp_cell u_cell (
          .gh (gi[i]),
          .ph (pi[i]),
          .gl (gi[J]),
          .pl (pi[J]),
          .g  (go[i]),
          .p  (g_pout.po[i])
        );
      end
    end
  end

  logic [WIDTH-1:0]     carries, sum_n;
  logic                 c32;
  logic [FLAG_BITS-1:0] flags, flags_n;

  assign carries = g_lvl[PREFIX_LEVELS-1].go;
  assign c32     = carries[WIDTH-1];
  assign sum_n   = s1_pb ^ {carries[WIDTH-2:0], s1_c0};

  always_comb begin
    flags_n            = '0;
    flags_n[FLAG_COUT] = s1_sub ? ~c32 : c32;
    flags_n[FLAG_OVF]  = (s1_a31 == s1_bi31) && (sum_n[WIDTH-1] != s1_a31);
    flags_n[FLAG_ZERO] = (sum_n == '0);
    flags_n[FLAG_NEG]  = sum_n[WIDTH-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      sum      <= '0;
      flags    <= '0;
    end else begin
      if (s1_adv) s1_valid <= in_valid;
      if (s2_adv) s2_valid <= s1_valid;
      if (s2_adv && s1_valid) begin
        sum   <= sum_n;
        flags <= flags_n;
      end
    end
  end

  // Stage-1 payload needs no reset: it is qualified by s1_valid.
  always_ff @(posedge clk) begin
    if (s1_adv && in_valid) begin
      s1_g    <= g_lvl[SPLIT_LEVEL-1].go;
      s1_p    <= g_lvl[SPLIT_LEVEL-1].g_pout.po;
      s1_pb   <= pb;
      s1_c0   <= c0;
      s1_sub  <= sub;
      s1_a31  <= a[WIDTH-1];
      s1_bi31 <= bi[WIDTH-1];
    end
  end

  assign cout = flags[FLAG_COUT];
  assign ovf  = flags[FLAG_OVF];
  assign zero = flags[FLAG_ZERO];
  assign neg  = flags[FLAG_NEG];

endmodule

// File: tb/tb_sklansky_addsub32_pipe.sv
// Directed bench for the pipelined add/subtract unit: arithmetic vectors,
// latency, backpressure, full-pipe streaming and reset while busy.
module tb_sklansky_addsub32_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [31:0] a, b;
  logic        cin, sub;
  logic        out_valid, out_ready;
  logic [31:0] sum;
  logic        cout, ovf, zero, neg;

  int pass_cnt  = 0;
  int total_cnt = 0;

  typedef struct {
    logic [31:0] va;
    logic [31:0] vb;
    logic        vcin;
    logic        vsub;
    logic [31:0] exp_sum;
    logic [3:0]  exp_f;   // {cout, ovf, zero, neg}
  } vec_t;

  sklansky_addsub32_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .zero      (zero),
    .neg       (neg)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one beat into an empty pipe and returns the number of cycles
  // after the accepting edge until out_valid (0 when it never shows up).
  task automatic send_beat(input vec_t v, output int lat,
                           output logic [31:0] s, output logic [3:0] f);
    a = v.va; b = v.vb; cin = v.vcin; sub = v.vsub;
    in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    lat = 0; s = '0; f = '0;
    for (int k = 1; k <= 4; k++) begin
      if (out_valid === 1'b1) begin
        lat = k; s = sum; f = {cout, ovf, zero, neg};
        break;
      end
      step();
    end
    step();
  endtask

  task automatic run_vectors(input string name, input vec_t v[4], input int n);
    int lat; logic [31:0] s; logic [3:0] f;
    for (int i = 0; i < n; i++) begin
      send_beat(v[i], lat, s, f);
      total_cnt++;
      if (lat !== 2) $display("FAIL %s[%0d] latency: got %0d required 2", name, i, lat);
      else pass_cnt++;
      total_cnt++;
      if (s !== v[i].exp_sum) $display("FAIL %s[%0d] sum: got %h required %h", name, i, s, v[i].exp_sum);
      else pass_cnt++;
      total_cnt++;
      if (f !== v[i].exp_f) $display("FAIL %s[%0d] flags: got %b required %b", name, i, f, v[i].exp_f);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    step(); step();
    total_cnt++;
    if (out_valid !== 1'b0) $display("FAIL reset out_valid: got %b required 0", out_valid);
    else pass_cnt++;
    total_cnt++;
    if (sum !== 32'h0) $display("FAIL reset sum: got %h required 00000000", sum);
    else pass_cnt++;
    total_cnt++;
    if ({cout, ovf, zero, neg} !== 4'b0000) $display("FAIL reset flags: got %b required 0000", {cout, ovf, zero, neg});
    else pass_cnt++;
    rst = 1'b0;
    step();
    total_cnt++;
    if (in_ready !== 1'b1) $display("FAIL reset in_ready: got %b required 1", in_ready);
    else pass_cnt++;
  endtask

  task automatic test_add();
    vec_t v[4];
    v[0] = '{32'h001F001F, 32'h0006000C, 1'b0, 1'b0, 32'h0025002B, 4'b0000};
    v[1] = '{32'h7FFFFFFF, 32'h7FFFFFFF, 1'b1, 1'b0, 32'hFFFFFFFF, 4'b0101};
    v[2] = v[0];
    v[3] = v[0];
    run_vectors("add", v, 2);
  endtask

  task automatic test_carry_wrap();
    vec_t v[4];
    v[0] = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 32'h00000000, 4'b1010};
    v[1] = '{32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b0, 32'hFFFFFFFF, 4'b0001};
    v[2] = v[0];
    v[3] = v[0];
    run_vectors("wrap", v, 2);
  endtask

  task automatic test_sub_ovf();
    vec_t v[4];
    v[0] = '{32'h00000000, 32'h00000001, 1'b0, 1'b1, 32'hFFFFFFFF, 4'b1001};
    v[1] = '{32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 4'b0100};
    v[2] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 4'b0101};
    v[3] = '{32'h00000005, 32'h00000003, 1'b1, 1'b1, 32'h00000001, 4'b0000};
    run_vectors("subovf", v, 4);
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_q[$];
    logic [31:0] e, prev_sum;
    bit          prev_stall = 1'b0;
    bit          extra = 1'b0;
    int          sent = 0, got = 0;
    cin = 1'b0; sub = 1'b0; prev_sum = '0;
    for (int cyc = 0; cyc < 40 && !(sent == 5 && got == 5); cyc++) begin
      in_valid  = (sent < 5);
      a         = 32'(sent + 1);
      b         = 32'(sent + 1);
      out_ready = !(cyc >= 2 && cyc <= 6);
      #1;
      if (cyc == 2) begin
        total_cnt++;
        if (in_ready !== 1'b0 || sent != 2)
          $display("FAIL bp_full: in_ready %b after %0d beats, required 0 after 2", in_ready, sent);
        else pass_cnt++;
      end
      if (prev_stall) begin
        total_cnt++;
        if (out_valid !== 1'b1 || sum !== prev_sum)
          $display("FAIL bp_hold: valid %b sum %h required 1 %h", out_valid, sum, prev_sum);
        else pass_cnt++;
      end
      if (out_valid === 1'b1 && out_ready) begin
        total_cnt++;
        if (exp_q.size() == 0) $display("FAIL bp_extra: got %h with nothing expected", sum);
        else begin
          e = exp_q.pop_front();
          if (sum !== e) $display("FAIL bp_order: got %h required %h", sum, e);
          else pass_cnt++;
        end
        got++;
      end
      prev_stall = (out_valid === 1'b1) && !out_ready;
      prev_sum   = sum;
      if (in_valid && in_ready === 1'b1) begin
        exp_q.push_back(32'((sent + 1) * 2));
        sent++;
      end
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    total_cnt++;
    if (got != 5 || sent != 5) $display("FAIL bp_count: got %0d of %0d outputs, required 5 of 5", got, sent);
    else pass_cnt++;
    for (int k = 0; k < 3; k++) begin
      if (out_valid !== 1'b0) extra = 1'b1;
      step();
    end
    total_cnt++;
    if (extra) $display("FAIL bp_dup: out_valid seen %b after drain, required 0", extra);
    else pass_cnt++;
  endtask

  task automatic test_full_pipe();
    logic [31:0] exp_q[$];
    logic [31:0] e;
    int          sent = 0, got = 0;
    cin = 1'b0; sub = 1'b0;
    for (int cyc = 0; cyc < 30 && got < 8; cyc++) begin
      in_valid  = (sent < 8);
      a         = 32'(sent) * 32'h01010101;
      b         = 32'h00000010;
      out_ready = (cyc >= 3);
      #1;
      if (cyc == 2) begin
        total_cnt++;
        if (in_ready !== 1'b0) $display("FAIL full_stall in_ready: got %b required 0", in_ready);
        else pass_cnt++;
      end
      if (cyc >= 3 && cyc <= 8) begin
        total_cnt++;
        if (in_ready !== 1'b1 || out_valid !== 1'b1)
          $display("FAIL full_stream cyc %0d: in_ready %b out_valid %b required 1 1", cyc, in_ready, out_valid);
        else pass_cnt++;
      end
      if (out_valid === 1'b1 && out_ready) begin
        total_cnt++;
        if (exp_q.size() == 0) $display("FAIL full_extra: got %h with nothing expected", sum);
        else begin
          e = exp_q.pop_front();
          if (sum !== e) $display("FAIL full_order: got %h required %h", sum, e);
          else pass_cnt++;
        end
        got++;
      end
      if (in_valid && in_ready === 1'b1) begin
        exp_q.push_back(a + b);
        sent++;
      end
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    total_cnt++;
    if (got != 8) $display("FAIL full_count: got %0d outputs required 8", got);
    else pass_cnt++;
    step();
  endtask

  task automatic test_reset_midflight();
    vec_t        v;
    int          lat;
    logic [31:0] s;
    logic [3:0]  f;
    out_ready = 1'b0; in_valid = 1'b1; cin = 1'b0; sub = 1'b0;
    a = 32'h11111111; b = 32'h22222222;
    step();
    a = 32'h33333333; b = 32'h44444444;
    step();
    in_valid = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    total_cnt++;
    if (out_valid !== 1'b0 || sum !== 32'h0 || {cout, ovf, zero, neg} !== 4'b0000)
      $display("FAIL midrst_clear: valid %b sum %h flags %b required 0 0 0", out_valid, sum, {cout, ovf, zero, neg});
    else pass_cnt++;
    total_cnt++;
    if (in_ready !== 1'b1) $display("FAIL midrst_ready: got %b required 1", in_ready);
    else pass_cnt++;
    v = '{32'h0000ABCD, 32'h00001234, 1'b0, 1'b0, 32'h0000BE01, 4'b0000};
    send_beat(v, lat, s, f);
    total_cnt++;
    if (lat !== 2) $display("FAIL midrst latency: got %0d required 2", lat);
    else pass_cnt++;
    total_cnt++;
    if (s !== v.exp_sum || f !== v.exp_f)
      $display("FAIL midrst result: got %h %b required %h %b", s, f, v.exp_sum, v.exp_f);
    else pass_cnt++;
    step();
    total_cnt++;
    if (out_valid !== 1'b0) $display("FAIL midrst ghost: out_valid %b required 0", out_valid);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_add();
    test_carry_wrap();
    test_sub_ovf();
    test_backpressure();
    test_full_pipe();
    test_reset_midflight();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/sklansky_addsub32_pipe.md
Name: sklansky_addsub32_pipe

Overview:
- Two-stage pipelined 32-bit add/subtract unit built on a Sklansky parallel-prefix carry network.
- Accepts operand pairs over a valid/ready handshake and returns the result with carry/borrow and status flags over a matching handshake.
- Provides the registered, back-pressured datapath counterpart to the combinational 32-bit Sklansky adder, for use in sequential datapaths.

Parameters:
- WIDTH, 32, operand/result width; the prefix network is sized for log2(WIDTH)=5 levels, and only 32 is supported.
- SPLIT_LEVEL, 3, number of prefix levels computed in stage 1; the remaining levels run in stage 2.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  operand beat present.
- in_ready  output  1  unit can accept a beat this cycle.
- a  input  32  operand A.
- b  input  32  operand B.
- cin  input  1  add: carry-in; sub: borrow-in.
- sub  input  1  0 = A+B+cin; 1 = A-B-cin.
- out_valid  output  1  result beat present.
- out_ready  input  1  downstream accepts the result.
- sum  output  32  result.
- cout  output  1  add: carry-out; sub: borrow-out (1 when A < B+cin unsigned).
- ovf  output  1  signed two's-complement overflow.
- zero  output  1  sum == 0.
- neg  output  1  sum[31].

Behaviour:
- Reset: with rst=1 at a rising edge, both stage valid bits clear. out_valid=0; sum, cout, ovf, zero and neg are 0. in_ready is 1 in the cycle after reset.
- Reset mid-operation discards all in-flight beats. No result is emitted for them.
- Transfers: an input transfer occurs when in_valid && in_ready. An output transfer occurs when out_valid && out_ready.
- Stage 1 (s1), on accept:
  - Register bi = sub ? ~b : b and c0 = sub ? ~cin : cin.
  - Register bitwise g=a&bi and p=a^bi, with c0 folded into bit 0: g0' = g0 | (p0 & c0).
  - Register group (G,P) after SPLIT_LEVEL Sklansky levels.
  - Register sub, plus a[31] and bi[31] for overflow.
- Stage 2 (s2):
  - Finish the remaining prefix levels and form carries c[i+1] = G[i:0]. sum[i] = p[i] ^ c[i], with c[0]=c0.
  - Raw carry-out is c32. cout = sub ? ~c32 : c32.
  - ovf = (a31 == bi31) && (sum31 != a31).
  - The result and flags are registered as outputs.
- Latency: exactly 2 cycles from the accepting edge to out_valid=1 with no backpressure. Throughput is 1 beat per cycle.
- Flow control, with s2_adv = !s2_valid || out_ready and s1_adv = !s1_valid || s2_adv:
  - in_ready = s1_adv, a combinational path from out_ready.
  - s1 loads when s1_adv. s2 loads from s1 when s2_adv.
  - A stage valid clears when its content moves on and nothing replaces it.
- Boundaries:
  - Full (both stages valid, out_ready=0): in_ready=0. The output holds sum and flags stable until accepted.
  - A simultaneous output and input transfer when full keeps the pipeline full with no bubble.
  - in_valid=0 inserts a bubble. Outputs keep their last value while out_valid=0; only out_valid is meaningful.
  - Wrap-around: modulo 2^32 arithmetic, with carry/borrow reported via cout.
  - No data may be lost or duplicated under any pattern of in_valid and out_ready.

Decomposition:
- Shared include/package holds ADDSUB_WIDTH=32, PREFIX_LEVELS=5 and the flag bit positions (when packed into a status word).
- Sub-module sklansky_gp_cell: combinational (G,P) merge, G = Gh | (Ph & Gl), P = Ph & Pl. It is instantiated per node in a generate loop in both stages.
- Handshake control stays inline in the top module.

Test Plan:
- Add, no backpressure: a=0x001F001F, b=0x0006000C, cin=0 -> sum=0x0025002B, cout=0, ovf=0, zero=0, exactly 2 cycles after accept.
- Carry wrap: a=0xFFFFFFFF, b=0, cin=1 -> sum=0x00000000, cout=1, zero=1. The same operands with cin=0 -> sum=0xFFFFFFFF, cout=0, neg=1.
- Subtract and overflow:
  - 0-1 (sub=1, cin=0) -> sum=0xFFFFFFFF, cout=1 (borrow), neg=1.
  - 0x80000000-1 -> sum=0x7FFFFFFF, ovf=1.
  - Add 0x7FFFFFFF+1 -> sum=0x80000000, ovf=1.
- Backpressure: stream 5 beats (a=i, b=i, i=1..5) with out_ready=0 for cycles 2-6.
  - in_ready drops after 2 beats are held.
  - Outputs 2,4,6,8,10 arrive in order with no loss or duplication, and sum stays stable while stalled.
- Full-pipe simultaneous transfer: pipeline full with out_ready=1 and in_valid=1 every cycle -> one result per cycle and in_ready held at 1.
- Reset mid-flight: assert rst for 1 cycle with 2 beats in flight -> out_valid=0 and all outputs 0 next cycle. Neither in-flight result ever appears, and a new beat afterwards returns its result 2 cycles after accept.
